// File: rtl/mmio_responder.sv
// -----------------------------------------------------------------------------
// mmio_responder
//
// Memory-mapped I/O responder for the mips memory bus. It decodes an 8-byte
// window at BASE and implements a GPIO output register, a synchronized GPIO
// input, a scratch register and a down-counting timer with auto-reload and an
// interrupt flag. It sits beside exmem. The top level returns iodata to the
// processor when iosel is 1, and returns exmem's memdata otherwise.
//
// Register map (byte offset within the window):
//   0 RW GPIO_OUT
//   1 RO GPIO_IN  (two-flop synchronized copy of gpio_in)
//   2 RW CTRL     bit0 en, bit1 autoreload, bit2 flag (write 1 to clear)
//   3 RW LOAD     (writing LOAD also sets COUNT)
//   4 RO COUNT
//   5 RW SCRATCH
//   6,7           read 0, writes ignored
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      synchronous, active-low reset
//   memread    in   1      processor read strobe
//   memwrite   in   1      processor write strobe
//   adr        in   WIDTH  processor byte address
//   writedata  in   WIDTH  processor write data
//   iodata     out  WIDTH  registered read data
//   iosel      out  1      1 = iodata carries a window read this cycle
//   gpio_in    in   WIDTH  asynchronous external inputs
//   gpio_out   out  WIDTH  GPIO output register
//   irq        out  1      timer interrupt (mirrors CTRL.flag)
// -----------------------------------------------------------------------------
module mmio_responder #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] BASE  = 8'hF8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] iodata,
    output logic             iosel,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic             irq
);

    // Register offsets inside the 8-byte window.
    localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
    localparam logic [2:0] OFF_CTRL     = 3'd2;
    localparam logic [2:0] OFF_LOAD     = 3'd3;
    localparam logic [2:0] OFF_COUNT    = 3'd4;
    localparam logic [2:0] OFF_SCRATCH  = 3'd5;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] iodata_q,   iodata_d;
    logic             iosel_q,    iosel_d;
    logic [WIDTH-1:0] gpio_out_q, gpio_out_d;
    logic [WIDTH-1:0] sync1_q,    sync2_q;
    logic             en_q,       en_d;
    logic             reload_q,   reload_d;
    logic             flag_q,     flag_d;
    logic [WIDTH-1:0] load_q,     load_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [WIDTH-1:0] scratch_q,  scratch_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       hit;
    logic [2:0] off;
    logic       wr_en;
    logic       rd_en;

    assign hit   = (adr[WIDTH-1:3] == BASE[WIDTH-1:3]);
    assign off   = adr[2:0];
    assign wr_en = memwrite & hit;
    assign rd_en = memread & hit;

    // ------------------------------------------------------------------
    // Read mux (pre-edge register values)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ctrl_rd;
    logic [WIDTH-1:0] rdata;

    assign ctrl_rd = {{(WIDTH-3){1'b0}}, flag_q, reload_q, en_q};

    always_comb begin
        // NOTE: every combinational output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        rdata = '0;
        case (off)
            OFF_GPIO_OUT: rdata = gpio_out_q;
            OFF_GPIO_IN:  rdata = sync2_q;
            OFF_CTRL:     rdata = ctrl_rd;
            OFF_LOAD:     rdata = load_q;
            OFF_COUNT:    rdata = count_q;
            OFF_SCRATCH:  rdata = scratch_q;
            default:      rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Timer step. It uses only pre-edge state, so a CTRL write in the
    // same cycle cannot change this cycle's step.
    // ------------------------------------------------------------------
    logic             tmr_expire;
    logic             tmr_en_next;
    logic [WIDTH-1:0] tmr_count_next;

    always_comb begin
        tmr_expire     = 1'b0;
        tmr_en_next    = en_q;
        tmr_count_next = count_q;
        if (en_q) begin
            if (count_q != '0) begin
                tmr_count_next = count_q - ONE;
            end else begin
                tmr_expire = 1'b1;
                if (reload_q) begin
                    tmr_count_next = load_q;
                end else begin
                    tmr_en_next = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The timer result is computed first, and a CPU
    // write then overrides it (LOAD/COUNT and en). For the flag the order
    // is reversed: a timer set beats a write-1-clear.
    // ------------------------------------------------------------------
    logic wr_ctrl;
    logic flag_clr;

    assign wr_ctrl  = wr_en && (off == OFF_CTRL);
    assign flag_clr = wr_ctrl && writedata[2];

    always_comb begin
        gpio_out_d = gpio_out_q;
        en_d       = tmr_en_next;
        reload_d   = reload_q;
        load_d     = load_q;
        count_d    = tmr_count_next;
        scratch_d  = scratch_q;

        if (tmr_expire) begin
            flag_d = 1'b1;
        end else if (flag_clr) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end

        if (wr_en) begin
            case (off)
                OFF_GPIO_OUT: gpio_out_d = writedata;
                OFF_CTRL: begin
                    en_d     = writedata[0];
                    reload_d = writedata[1];
                end
                OFF_LOAD: begin
                    load_d  = writedata;
                    count_d = writedata;
                end
                OFF_SCRATCH: scratch_d = writedata;
                default: ;  // RO offsets and unused offsets ignore writes
            endcase
        end

        // A read captures the pre-edge register. Otherwise iodata holds its value.
        iosel_d  = rd_en;
        iodata_d = rd_en ? rdata : iodata_q;
    end

    // ------------------------------------------------------------------
    // Registers with synchronous active-low reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples pre-edge values, regardless of statement order.
        if (!reset) begin
            iodata_q   <= '0;
            iosel_q    <= 1'b0;
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            en_q       <= 1'b0;
            reload_q   <= 1'b0;
            flag_q     <= 1'b0;
            load_q     <= '0;
            count_q    <= '0;
            scratch_q  <= '0;
        end else begin
            iodata_q   <= iodata_d;
            iosel_q    <= iosel_d;
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            en_q       <= en_d;
            reload_q   <= reload_d;
            flag_q     <= flag_d;
            load_q     <= load_d;
            count_q    <= count_d;
            scratch_q  <= scratch_d;
        end
    end

    assign iodata   = iodata_q;
    assign iosel    = iosel_q;
    assign gpio_out = gpio_out_q;
    assign irq      = flag_q;

endmodule
